// File: rtl/lockstep_compare_unit_if.sv
// Core-side TCDM request taps for all master/checker cores of the cluster.
// Core 2k is the master of pair k, core 2k+1 its delayed checker.
interface lockstep_compare_unit_if #(
  parameter int NB_PAIRS = 4,
  parameter int ADDR_W   = 32
);
  logic [2*NB_PAIRS-1:0]        req_i;
  logic [2*NB_PAIRS*ADDR_W-1:0] add_i;
  logic [2*NB_PAIRS-1:0]        wen_i;
  logic [2*NB_PAIRS*4-1:0]      be_i;
  logic [2*NB_PAIRS*32-1:0]     wdata_i;

  modport master (output req_i, add_i, wen_i, be_i, wdata_i);
  modport slave  (input  req_i, add_i, wen_i, be_i, wdata_i);
endinterface

// File: rtl/lockstep_compare_unit.sv
// Passive delayed-lockstep checker: delays each master request by DELAY cycles,
// compares it with the checker's current request and keeps sticky per-pair fault state.
module lockstep_compare_unit #(
  parameter int NB_PAIRS = 4,
  parameter int DELAY    = 2,
  parameter int ADDR_W   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       lockstep_mode,
  lockstep_compare_unit_if.slave     tcdm,
  input  logic [NB_PAIRS-1:0]        err_clr_i,
  output logic [NB_PAIRS-1:0]        err_o,
  output logic                       irq_o,
  output logic [NB_PAIRS*8-1:0]      mismatch_cnt_o,
  output logic [NB_PAIRS*ADDR_W-1:0] fault_add_o
);

  typedef struct packed {
    logic              vld;
    logic              req;
    logic [ADDR_W-1:0] add;
    logic              wen;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } req_t;

  for (genvar k = 0; k < NB_PAIRS; k++) begin : g_pair
    localparam int M = 2*k;
    localparam int C = 2*k + 1;

    req_t              pipe_q [DELAY];
    req_t              master_s;
    req_t              tail_s;
    logic              chk_req;
    logic [ADDR_W-1:0] chk_add;
    logic              chk_wen;
    logic [3:0]        chk_be;
    logic [31:0]       chk_wdata;
    logic              mismatch_s;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] fault_q;

    assign master_s = {lockstep_mode, tcdm.req_i[M], tcdm.add_i[M*ADDR_W +: ADDR_W],
                       tcdm.wen_i[M], tcdm.be_i[M*4 +: 4], tcdm.wdata_i[M*32 +: 32]};
    assign tail_s    = pipe_q[DELAY-1];
    assign chk_req   = tcdm.req_i[C];
    assign chk_add   = tcdm.add_i[C*ADDR_W +: ADDR_W];
    assign chk_wen   = tcdm.wen_i[C];
    assign chk_be    = tcdm.be_i[C*4 +: 4];
    assign chk_wdata = tcdm.wdata_i[C*32 +: 32];

    // Leaving lockstep invalidates every in-flight entry, forcing a full warm-up on re-entry.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= master_s;
        for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        if (!lockstep_mode) begin
          for (int i = 0; i < DELAY; i++) pipe_q[i].vld <= 1'b0;
        end
      end
    end

    always_comb begin
      mismatch_s = 1'b0;
      if (lockstep_mode && tail_s.vld) begin
        if (tail_s.req != chk_req) begin
          mismatch_s = 1'b1;
        end else if (tail_s.req) begin
          mismatch_s = (tail_s.add != chk_add) || (tail_s.wen != chk_wen) ||
                       (tail_s.be != chk_be) ||
                       (!tail_s.wen && (tail_s.wdata != chk_wdata));
        end
      end
    end

    // A mismatch coinciding with a clear wins and restarts the record from this fault.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        err_q   <= 1'b0;
        cnt_q   <= '0;
        fault_q <= '0;
      end else if (mismatch_s) begin
        err_q <= 1'b1;
        if (err_clr_i[k])         cnt_q <= 8'd1;
        else if (cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
        if (!err_q || err_clr_i[k]) fault_q <= tail_s.add;
      end else if (err_clr_i[k]) begin
        err_q   <= 1'b0;
        cnt_q   <= '0;
        fault_q <= '0;
      end
    end

    assign err_o[k]                        = err_q;
    assign mismatch_cnt_o[k*8 +: 8]        = cnt_q;
    assign fault_add_o[k*ADDR_W +: ADDR_W] = fault_q;
  end

  assign irq_o = |err_o;

endmodule
